// File: rtl/nvme_parfifo.sv
// nvme_parfifo: parity-protected elastic buffer.
// Parity is checked when a word enters and checked again when it leaves. An
// entry error means the link from the parity generator corrupted the word.
// An exit error on a word that entered clean means the storage corrupted it.
module nvme_parfifo #(
  parameter int width               = 128,
  parameter int bits_per_parity_bit = 8,
  parameter int pwidth              = (width + bits_per_parity_bit - 1) / bits_per_parity_bit,
  parameter int depth               = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     oddpar,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [width-1:0]         wr_data,
  input  logic [pwidth-1:0]        wr_datap,
  input  logic                     inj_err,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [width-1:0]         rd_data,
  output logic [pwidth-1:0]        rd_datap,
  output logic [$clog2(depth):0]   count,
  output logic                     in_perror,
  output logic                     out_perror,
  output logic [1:0]               perror_sticky,
  input  logic                     perror_clr
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_cnt = (aw + 1)'(depth);

  // The word is zero-padded up to a whole number of groups. Padding bits do
  // not change an XOR, so a short final group needs no special case.
  function automatic logic [pwidth-1:0] calc_par(input logic [width-1:0] d,
                                                 input logic             odd);
    logic [pwidth*bits_per_parity_bit-1:0] pad;
    logic [pwidth-1:0]                     p;
    pad              = '0;
    pad[width-1:0]   = d;
    p                = '0;
    for (int i = 0; i < pwidth; i++) begin
      p[i] = odd ^ (^pad[i*bits_per_parity_bit +: bits_per_parity_bit]);
    end
    return p;
  endfunction

  logic [width-1:0]  mem_q  [depth];
  logic [pwidth-1:0] memp_q [depth];

  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [aw:0]   count_q, count_d;
  logic          inj_q, inj_d;
  logic          in_perror_q, in_perror_d;
  logic          out_perror_q, out_perror_d;
  logic [1:0]    sticky_q, sticky_d;

  logic              wr_fire;
  logic              rd_fire;
  logic              in_bad;
  logic              out_bad;
  logic [pwidth-1:0] flip;
  logic [pwidth-1:0] store_p;

  assign wr_ready      = (count_q != depth_cnt);
  assign rd_valid      = (count_q != '0);
  assign rd_data       = mem_q[rd_ptr_q];
  assign rd_datap      = memp_q[rd_ptr_q];
  assign count         = count_q;
  assign in_perror     = in_perror_q;
  assign out_perror    = out_perror_q;
  assign perror_sticky = sticky_q;

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = rd_valid & rd_ready;

  // Both checks compare against what was actually received or stored; an
  // injected flip is applied after the entry check so it only shows on exit.
  always_comb begin
    flip    = '0;
    flip[0] = inj_q;
    store_p = wr_datap ^ flip;
    in_bad  = (calc_par(wr_data, oddpar) != wr_datap);
    out_bad = (calc_par(rd_data, oddpar) != rd_datap);
  end

  // Next-state for pointers, occupancy, injection flag and error reporting.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    inj_d        = inj_q;
    in_perror_d  = 1'b0;
    out_perror_d = 1'b0;
    sticky_d     = perror_clr ? 2'b00 : sticky_q;

    if (wr_fire) begin
      wr_ptr_d    = wr_ptr_q + aw'(1);
      in_perror_d = in_bad;
      inj_d       = 1'b0;
    end
    if (inj_err) begin
      inj_d = 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d     = rd_ptr_q + aw'(1);
      out_perror_d = out_bad;
    end

    if (wr_fire && !rd_fire) begin
      count_d = count_q + (aw + 1)'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - (aw + 1)'(1);
    end

    // A set in the same cycle as a clear must win.
    if (in_perror_d) begin
      sticky_d[0] = 1'b1;
    end
    if (out_perror_d) begin
      sticky_d[1] = 1'b1;
    end
  end

  // Control state; reset discards all entries by zeroing pointers and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inj_q        <= 1'b0;
      in_perror_q  <= 1'b0;
      out_perror_q <= 1'b0;
      sticky_q     <= 2'b00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inj_q        <= inj_d;
      in_perror_q  <= in_perror_d;
      out_perror_q <= out_perror_d;
      sticky_q     <= sticky_d;
    end
  end

  // Storage array is not reset; only accepted writes update it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q]  <= wr_data;
      memp_q[wr_ptr_q] <= store_p;
    end
  end

endmodule
